fifo_top: RTL and testbench

- Single-clock synchronous FIFO buffer with registered read data and full/empty status flags.
- Decouples a byte-stream producer from a consumer inside one clock domain.
- Used as a generic elastic buffer between datapath stages.

---
 rtl/fifo_top.sv | 87 ++++++++
 tb/tb_fifo_top.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_top.sv
// ============================================================================
// Module   : fifo_top
// Brief    : Single-clock synchronous FIFO with registered read data and
//            full/empty flags. Define FIFO_COUNT_EN to add o_fifo_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_top #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   o_fifo_count
`endif
);

  localparam int                c_depth   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_ptr_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // The extra pointer MSB distinguishes a full wrap from an empty match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  assign w_wr_accept = wr_en && !w_full;
  assign w_rd_accept = rd_en && !w_empty;
  assign w_wr_addr   = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr   = r_rd_ptr[ADDR_WIDTH-1:0];

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else if (w_rd_accept) begin
      r_rd_ptr  <= r_rd_ptr + c_ptr_one;
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign rd_data      = r_rd_data;
  assign o_fifo_full  = w_full;
  assign o_fifo_empty = w_empty;

`ifdef FIFO_COUNT_EN
  assign o_fifo_count = r_wr_ptr - r_rd_ptr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_top.sv
// ============================================================================
// Module   : tb_fifo_top
// Brief    : Self-checking bench for fifo_top against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_top;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          o_fifo_full;
  logic          o_fifo_empty;
`ifdef FIFO_COUNT_EN
  logic [AW:0]   o_fifo_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_rd = '0;

  fifo_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .o_fifo_full  (o_fifo_full),
    .o_fifo_empty (o_fifo_empty)
`ifdef FIFO_COUNT_EN
    ,
    .o_fifo_count (o_fifo_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":empty"}, {31'd0, o_fifo_empty}, {31'd0, model_q.size() == 0});
    chk({tag, ":full"},  {31'd0, o_fifo_full},  {31'd0, model_q.size() == DEPTH});
    chk({tag, ":rd_data"}, {24'd0, rd_data}, {24'd0, exp_rd});
`ifdef FIFO_COUNT_EN
    chk({tag, ":count"}, {28'd0, o_fifo_count}, model_q.size());
`endif
  endtask

  // One clock cycle of stimulus; the model decides acceptance from the
  // occupancy seen before the edge.
  task automatic step(input string tag, input logic we, input logic [DW-1:0] wd, input logic re);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (re && !was_empty) exp_rd = model_q.pop_front();
    if (we && !was_full)  model_q.push_back(wd);
    #1;
    chk_all(tag);
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk_all("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("after_release");
    step("read_empty", 1'b0, 8'h00, 1'b1);

    // Fill past capacity
    for (int i = 1; i <= 10; i++) step("fill", 1'b1, DW'(i), 1'b0);

    // Drain past empty
    for (int i = 1; i <= 10; i++) step("drain", 1'b0, 8'h00, 1'b1);
    chk("drain_last", {24'd0, rd_data}, 32'h08);

    // Preload then sustained simultaneous traffic across pointer wrap
    for (int i = 0; i < 3; i++) step("preload", 1'b1, 8'hA0 + DW'(i), 1'b0);
    for (int i = 0; i < 20; i++) step("simul", 1'b1, 8'hB0 + DW'(i), 1'b1);
    chk("simul_occupancy", model_q.size(), 32'd3);

    // Empty boundary: simultaneous request stores one entry, no read
    while (model_q.size() != 0) step("empty_out", 1'b0, 8'h00, 1'b1);
    step("empty_simul", 1'b1, 8'h5A, 1'b1);
    step("empty_simul_rd", 1'b0, 8'h00, 1'b1);

    // Full boundary: simultaneous request reads oldest, drops new data
    for (int i = 0; i < DEPTH; i++) step("to_full", 1'b1, 8'hC0 + DW'(i), 1'b0);
    step("full_simul", 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("random", 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Asynchronous reset between edges with 5 entries stored
    while (model_q.size() != 0) step("pre_rst_drain", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step("pre_rst_fill", 1'b1, 8'h70 + DW'(i), 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    exp_rd = '0;
    chk_all("async_reset");
    #1;
    rst = 1'b1;
    step("post_rst_read", 1'b0, 8'h00, 1'b1);
    step("post_rst_write", 1'b1, 8'h33, 1'b0);
    step("post_rst_read2", 1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
